// File: rtl/bias_param_pkg.sv
// Shared types for the writable bias/weight parameter loader: FSM states and
// beat-word width helpers.
package bias_param_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_DATA_WIDTH  = 16;
  localparam int DEF_PARALLELISM = 1;

  function automatic int word_width(input int data_width, input int parallelism);
    return data_width * parallelism;
  endfunction

  localparam int DEF_WORD_W = DEF_DATA_WIDTH * DEF_PARALLELISM;

  typedef logic [DEF_WORD_W-1:0] beat_word_t;

endpackage

// File: rtl/bias_param_ram.sv
// Simple dual-port parameter RAM: one write port, one read port with two
// ce-gated output registers, matching the ROM sources' read timing.
module bias_param_ram #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 32,
  parameter int AWIDTH = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AWIDTH-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic [AWIDTH-1:0] i_rd_addr,
  input  logic              i_rd_ce,
  output logic [WIDTH-1:0]  o_rd_data
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_s1;
  logic [WIDTH-1:0] r_rd_s2;

  // The spare address bit only matters for out-of-range reads, whose data is undefined.
  logic w_unused_hi;
  assign w_unused_hi = ^{i_waddr[AWIDTH-1:IDX_W], i_rd_addr[AWIDTH-1:IDX_W]};

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr[IDX_W-1:0]] <= i_wdata;
    end
  end

  // Non-blocking read of the array gives read-before-write on an address collision.
  always_ff @(posedge clk) begin
    if (i_rd_ce) begin
      r_rd_s1 <= r_mem[i_rd_addr[IDX_W-1:0]];
      r_rd_s2 <= r_rd_s1;
    end
  end

  assign o_rd_data = r_rd_s2;

endmodule

// File: rtl/bias_param_loader.sv
// Loads a stream of parameter beats into RAM in address order and flags when a
// full tensor is resident; the read port keeps the 2-cycle ce-gated ROM timing.
module bias_param_loader
  import bias_param_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int PARALLELISM = 1,
  parameter int DEPTH       = 32,
  parameter int AWIDTH      = $clog2(DEPTH) + 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [DATA_WIDTH-1:0]             data_in [PARALLELISM-1:0],
  input  logic                              data_in_valid,
  output logic                              data_in_ready,
  output logic                              busy,
  output logic                              load_done,
  output logic                              overflow_err,
  input  logic [AWIDTH-1:0]                 rd_addr,
  input  logic                              rd_ce,
  output logic [DATA_WIDTH*PARALLELISM-1:0] rd_data,
  output state_t                            dbg_state
);

  localparam int WORD_W = word_width(DATA_WIDTH, PARALLELISM);
  typedef logic [WORD_W-1:0] word_t;

  // Handshake: a beat transfers on a rising edge where data_in_valid and
  // data_in_ready are both high; ready is a pure decode of the registered state.
  state_t            r_state;
  state_t            w_next_state;
  logic [AWIDTH-1:0] r_wr_ptr;
  logic              r_overflow;
  logic              w_hs;
  logic              w_last;
  word_t             w_beat;

  assign w_hs   = (r_state == LOAD) && data_in_valid;
  assign w_last = (r_wr_ptr == AWIDTH'(DEPTH - 1));

  always_comb begin
    w_beat = '0;
    for (int j = 0; j < PARALLELISM; j++) begin
      w_beat[DATA_WIDTH*j +: DATA_WIDTH] = data_in[j];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: if (start) w_next_state = LOAD;
      LOAD: begin
        if (start) w_next_state = LOAD;
        else if (w_hs && w_last) w_next_state = DONE;
      end
      DONE: if (start) w_next_state = LOAD;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    data_in_ready = 1'b0;
    busy          = 1'b0;
    load_done     = 1'b0;
    case (r_state)
      LOAD: begin
        data_in_ready = 1'b1;
        busy          = 1'b1;
      end
      DONE:    load_done = 1'b1;
      default: ;
    endcase
  end

  // A start coincident with a handshake still writes that beat at the old pointer.
  always_ff @(posedge clk) begin
    if (rst || start) begin
      r_wr_ptr <= '0;
    end else if (w_hs) begin
      r_wr_ptr <= w_last ? '0 : r_wr_ptr + AWIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || start) begin
      r_overflow <= 1'b0;
    end else if ((r_state == DONE) && data_in_valid) begin
      r_overflow <= 1'b1;
    end
  end

  assign overflow_err = r_overflow;
  assign dbg_state    = r_state;

  bias_param_ram #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH),
    .AWIDTH(AWIDTH)
  ) u_ram (
    .clk      (clk),
    .i_we     (w_hs),
    .i_waddr  (r_wr_ptr),
    .i_wdata  (w_beat),
    .i_rd_addr(rd_addr),
    .i_rd_ce  (rd_ce),
    .o_rd_data(rd_data)
  );

endmodule

// File: tb/tb_bias_param_loader.sv
// Directed bench for bias_param_loader (DEPTH=4, PARALLELISM=2): reads feed a
// scoreboard queue checked by a monitor as the read pipeline produces data.
module tb_bias_param_loader;
  import bias_param_pkg::*;

  localparam int DW  = 16;
  localparam int PAR = 2;
  localparam int DEP = 4;
  localparam int AW  = 3;
  localparam int W   = DW * PAR;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] data_in [PAR-1:0];
  logic          data_in_valid;
  logic          data_in_ready;
  logic          busy;
  logic          load_done;
  logic          overflow_err;
  logic [AW-1:0] rd_addr;
  logic          rd_ce;
  logic [W-1:0]  rd_data;
  state_t        dbg_state;

  logic [W-1:0] exp_q[$];
  int           total = 0;
  int           bad   = 0;
  logic         tb_tag = 1'b0;
  logic         v1     = 1'b0;
  logic         fresh  = 1'b0;

  bias_param_loader #(
    .DATA_WIDTH (DW),
    .PARALLELISM(PAR),
    .DEPTH      (DEP),
    .AWIDTH     (AW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .data_in      (data_in),
    .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready),
    .busy         (busy),
    .load_done    (load_done),
    .overflow_err (overflow_err),
    .rd_addr      (rd_addr),
    .rd_ce        (rd_ce),
    .rd_data      (rd_data),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- read-pipeline tag model and monitor ----------------
  always @(posedge clk) begin
    if (rd_ce) v1 <= tb_tag;
    fresh <= rd_ce && v1;
  end

  always @(negedge clk) begin
    if (fresh) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL rd_data: got %h with no read pending", rd_data);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (rd_data !== e) begin
          bad++;
          $display("FAIL rd_data: got %h expected %h", rd_data, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic beat(input logic [DW-1:0] e0, input logic [DW-1:0] e1);
    int n = 0;
    data_in[0]    = e0;
    data_in[1]    = e1;
    data_in_valid = 1'b1;
    while (!data_in_ready && n < 20) begin
      step();
      n++;
    end
    check("ready_wait", W'(data_in_ready), W'(1));
    step();
    data_in_valid = 1'b0;
  endtask

  task automatic issue_read(input logic [AW-1:0] a, input logic [W-1:0] exp);
    rd_addr = a;
    rd_ce   = 1'b1;
    tb_tag  = 1'b1;
    exp_q.push_back(exp);
    step();
    tb_tag = 1'b0;
    rd_ce  = 1'b0;
  endtask

  task automatic flush();
    rd_ce  = 1'b1;
    tb_tag = 1'b0;
    idle(2);
    rd_ce = 1'b0;
  endtask

  task automatic read_one(input logic [AW-1:0] a, input logic [W-1:0] exp);
    issue_read(a, exp);
    flush();
  endtask

  task automatic check_status(input string tag, input logic rdy, input logic bsy,
                              input logic dn, input logic ovf);
    check({tag, "_ready"}, W'(data_in_ready), W'(rdy));
    check({tag, "_busy"},  W'(busy),          W'(bsy));
    check({tag, "_done"},  W'(load_done),     W'(dn));
    check({tag, "_ovf"},   W'(overflow_err),  W'(ovf));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst           = 1'b1;
    start         = 1'b0;
    data_in[0]    = '0;
    data_in[1]    = '0;
    data_in_valid = 1'b0;
    rd_addr       = '0;
    rd_ce         = 1'b0;
    idle(3);
    check_status("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset_state", W'(dbg_state), W'(IDLE));
    rst = 1'b0;
    idle(2);
    check("idle_ready", W'(data_in_ready), W'(0));

    // Basic back-to-back load
    pulse_start();
    check_status("start", 1'b1, 1'b1, 1'b0, 1'b0);
    beat(16'h0001, 16'h0002);
    beat(16'h0003, 16'h0004);
    beat(16'h0005, 16'h0006);
    check("done_early", W'(load_done), W'(0));
    beat(16'h0007, 16'h0008);
    check_status("basic_done", 1'b0, 1'b0, 1'b1, 1'b0);
    read_one(3'd0, 32'h0002_0001);
    read_one(3'd1, 32'h0004_0003);
    read_one(3'd2, 32'h0006_0005);
    read_one(3'd3, 32'h0008_0007);

    // Overflow in DONE: flagged, not written, cleared by start
    data_in[0]    = 16'hDEAD;
    data_in[1]    = 16'hDEAD;
    data_in_valid = 1'b1;
    step();
    data_in_valid = 1'b0;
    check_status("ovf", 1'b0, 1'b0, 1'b1, 1'b1);
    read_one(3'd0, 32'h0002_0001);
    pulse_start();
    check_status("ovf_clr", 1'b1, 1'b1, 1'b0, 1'b0);

    // Gapped load, with a same-cycle read of address 2 during its write
    idle($urandom_range(0, 3));
    beat(16'h0011, 16'h0012);
    idle($urandom_range(1, 3));
    beat(16'h0013, 16'h0014);
    idle($urandom_range(1, 3));
    data_in[0]    = 16'h0015;
    data_in[1]    = 16'h0016;
    data_in_valid = 1'b1;
    issue_read(3'd2, 32'h0006_0005);
    data_in_valid = 1'b0;
    flush();
    check("gap_done_early", W'(load_done), W'(0));
    idle($urandom_range(1, 3));
    beat(16'h0017, 16'h0018);
    check_status("gap_done", 1'b0, 1'b0, 1'b1, 1'b0);
    read_one(3'd0, 32'h0012_0011);
    read_one(3'd1, 32'h0014_0013);
    read_one(3'd2, 32'h0016_0015);
    read_one(3'd3, 32'h0018_0017);

    // Restart colliding with the handshake of beat 1
    pulse_start();
    beat(16'h000A, 16'h000B);
    data_in[0]    = 16'h0055;
    data_in[1]    = 16'h0000;
    data_in_valid = 1'b1;
    start         = 1'b1;
    step();
    data_in_valid = 1'b0;
    start         = 1'b0;
    check_status("collide", 1'b1, 1'b1, 1'b0, 1'b0);
    beat(16'h000C, 16'h000D);
    read_one(3'd0, 32'h000D_000C);
    read_one(3'd1, 32'h0000_0055);
    read_one(3'd2, 32'h0016_0015);

    // Reset after two beats of a load
    beat(16'h000E, 16'h000F);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_status("midrst", 1'b0, 1'b0, 1'b0, 1'b0);
    check("midrst_state", W'(dbg_state), W'(IDLE));
    read_one(3'd1, 32'h000F_000E);
    pulse_start();
    beat(16'h0021, 16'h0022);
    beat(16'h0023, 16'h0024);
    beat(16'h0025, 16'h0026);
    beat(16'h0027, 16'h0028);
    check_status("reload", 1'b0, 1'b0, 1'b1, 1'b0);
    read_one(3'd0, 32'h0022_0021);
    read_one(3'd1, 32'h0024_0023);
    read_one(3'd2, 32'h0026_0025);
    read_one(3'd3, 32'h0028_0027);

    // Read stall: rd_data holds while rd_ce is low
    issue_read(3'd0, 32'h0022_0021);
    issue_read(3'd1, 32'h0024_0023);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_hold", rd_data, 32'h0022_0021);
    end
    flush();
    read_one(3'd3, 32'h0028_0027);

    begin
      int n = 0;
      while (exp_q.size() != 0 && n < 50) begin
        step();
        n++;
      end
    end
    check("queue_drained", W'(exp_q.size()), W'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
